spring_particle: RTL and testbench

SPRING_PARTICLE -- requirements
Module: spring_particle

---
 rtl/spring_particle.sv | 374 +++++++++++++++++++++++++++++++++++++
 tb/tb_spring_particle.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/spring_particle.sv
`default_nettype none
// ============================================================================
//  Module      : spring_particle
//  Description : One particle of a mass-spring mesh. Each step first applies
//                Verlet integration with an external force. It then visits the
//                coupled neighbours one at a time and accumulates a spring
//                plus damping acceleration for each. Last, the position is
//                clamped into [0, BOUND).
//                All datapath arithmetic is W-bit two's complement. The
//                neighbour stages share a single W x W multiplier and a
//                single signed divider.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk            : clock, all state changes on the rising edge
//    reset          : synchronous active-high reset
//    start          : request one simulation step (sampled in IDLE only)
//    force_x/_y     : signed external force per axis
//    nbr_x/_y       : packed neighbour positions, neighbour i at [i*W +: W]
//    nbr_vx/_vy     : packed neighbour velocities
//    busy           : high while a step is in progress
//    done           : one-cycle pulse when a step completes
//    x/y            : registered position
//    vel_x/vel_y    : registered velocity
// ============================================================================
module spring_particle #(
    parameter int N_NEIGH     = 3,
    parameter int W           = 16,
    parameter int FRAC        = 4,
    parameter int INIT_X      = 128,
    parameter int INIT_Y      = 128,
    parameter int REST        = 64,
    parameter int K_SHIFT     = 1,
    parameter int DAMP_SHIFT  = 2,
    parameter int FORCE_SHIFT = 8,
    parameter int BOUND       = 256,
    parameter int PINNED      = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic signed [W-1:0]    force_x,
    input  logic signed [W-1:0]    force_y,
    input  logic [N_NEIGH*W-1:0]   nbr_x,
    input  logic [N_NEIGH*W-1:0]   nbr_y,
    input  logic [N_NEIGH*W-1:0]   nbr_vx,
    input  logic [N_NEIGH*W-1:0]   nbr_vy,
    output logic                   busy,
    output logic                   done,
    output logic signed [W-1:0]    x,
    output logic signed [W-1:0]    y,
    output logic signed [W-1:0]    vel_x,
    output logic signed [W-1:0]    vel_y
);

    localparam int KW = (N_NEIGH > 1) ? $clog2(N_NEIGH) : 1;

    localparam logic [KW-1:0]       C_K_LAST   = KW'(N_NEIGH - 1);
    localparam logic [KW-1:0]       C_K_ONE    = KW'(1);
    localparam logic signed [W-1:0] C_INIT_X   = W'(INIT_X);
    localparam logic signed [W-1:0] C_INIT_Y   = W'(INIT_Y);
    localparam logic signed [W-1:0] C_REST     = W'(REST);
    localparam logic signed [W-1:0] C_BOUND    = W'(BOUND);
    localparam logic signed [W-1:0] C_BOUND_M1 = W'(BOUND - 1);
    localparam logic signed [W-1:0] C_ONE      = W'(1);

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        INTEG = 4'd1,
        DX2   = 4'd2,
        DY2   = 4'd3,
        DIST  = 4'd4,
        UX    = 4'd5,
        UY    = 4'd6,
        DMX   = 4'd7,
        DMY   = 4'd8,
        ACCX  = 4'd9,
        ACCY  = 4'd10,
        CLAMP = 4'd11,
        DONE  = 4'd12
    } state_t;

    state_t            state_q, state_d;
    logic [KW-1:0]     k_q, k_d;

    // Particle state
    logic signed [W-1:0] px_q, px_d, pxo_q, pxo_d;
    logic signed [W-1:0] py_q, py_d, pyo_q, pyo_d;
    logic signed [W-1:0] vx_q, vx_d, vy_q, vy_d;
    logic signed [W-1:0] ax_q, ax_d, ay_q, ay_d;

    // Input snapshots taken when a step is accepted
    logic signed [W-1:0]  fx_q, fx_d, fy_q, fy_d;
    logic [N_NEIGH*W-1:0] snx_q, snx_d, sny_q, sny_d;
    logic [N_NEIGH*W-1:0] snvx_q, snvx_d, snvy_q, snvy_d;

    // Per-neighbour intermediates
    logic signed [W-1:0] dx_q, dx_d, dy_q, dy_d;
    logic signed [W-1:0] dx2_q, dx2_d, dy2_q, dy2_d;
    logic signed [W-1:0] d_q, d_d;
    logic signed [W-1:0] ux_q, ux_d, uy_q, uy_d;
    logic signed [W-1:0] dmx_q, dmx_d, dmy_q, dmy_d;

    // ------------------------------------------------------------------
    // Neighbour unpacking and selection of neighbour k
    // ------------------------------------------------------------------
    logic signed [W-1:0] w_nx_arr  [N_NEIGH];
    logic signed [W-1:0] w_ny_arr  [N_NEIGH];
    logic signed [W-1:0] w_nvx_arr [N_NEIGH];
    logic signed [W-1:0] w_nvy_arr [N_NEIGH];

    for (genvar gi = 0; gi < N_NEIGH; gi++) begin : g_unpack
        assign w_nx_arr[gi]  = snx_q[gi*W +: W];
        assign w_ny_arr[gi]  = sny_q[gi*W +: W];
        assign w_nvx_arr[gi] = snvx_q[gi*W +: W];
        assign w_nvy_arr[gi] = snvy_q[gi*W +: W];
    end

    logic signed [W-1:0] w_nx, w_ny, w_nvx, w_nvy;
    assign w_nx  = w_nx_arr[k_q];
    assign w_ny  = w_ny_arr[k_q];
    assign w_nvx = w_nvx_arr[k_q];
    assign w_nvy = w_nvy_arr[k_q];

    // ------------------------------------------------------------------
    // Verlet integration terms (fy is the negated y force)
    // ------------------------------------------------------------------
    logic signed [W-1:0] w_fy_neg, w_pxn, w_pyn, w_vxn, w_vyn;
    assign w_fy_neg = -fy_q;
    assign w_pxn    = (px_q <<< 1) - pxo_q + (ax_q >>> 2) + (fx_q >>> FORCE_SHIFT);
    assign w_pyn    = (py_q <<< 1) - pyo_q + (ay_q >>> 2) + (w_fy_neg >>> FORCE_SHIFT);
    assign w_vxn    = (w_pxn - px_q) >>> 1;
    assign w_vyn    = (w_pyn - py_q) >>> 1;

    // ------------------------------------------------------------------
    // Per-neighbour combinational terms
    // ------------------------------------------------------------------
    logic signed [W-1:0] w_dx, w_dy, w_dvx, w_dvy, w_d_sum, w_acc_term;
    logic                w_skip;
    assign w_dx       = px_q - w_nx;
    assign w_dy       = py_q - w_ny;
    assign w_dvx      = vx_q - w_nvx;
    assign w_dvy      = vy_q - w_nvy;
    assign w_d_sum    = dx2_q + dy2_q;
    assign w_skip     = w_d_sum[W-1] | (w_d_sum == '0);
    // Spring stretch plus damping, shared by ACCX and ACCY
    assign w_acc_term = ((d_q - C_REST) <<< K_SHIFT) + ((dmx_q + dmy_q) >>> DAMP_SHIFT);

    // ------------------------------------------------------------------
    // Shared multiplier: operands sign-extended to 2W, product shifted
    // arithmetically by FRAC and then truncated back to W.
    // ------------------------------------------------------------------
    logic signed [2*W-1:0] w_mul_a, w_mul_b;
    logic signed [W-1:0]   w_mul_w;

    always_comb begin
        w_mul_a = '0;
        w_mul_b = '0;
        case (state_q)
            DX2:  begin w_mul_a = (2*W)'(w_dx);       w_mul_b = (2*W)'(w_dx); end
            DY2:  begin w_mul_a = (2*W)'(w_dy);       w_mul_b = (2*W)'(w_dy); end
            DMX:  begin w_mul_a = (2*W)'(w_dvx);      w_mul_b = (2*W)'(ux_q); end
            DMY:  begin w_mul_a = (2*W)'(w_dvy);      w_mul_b = (2*W)'(uy_q); end
            ACCX: begin w_mul_a = (2*W)'(w_acc_term); w_mul_b = (2*W)'(ux_q); end
            ACCY: begin w_mul_a = (2*W)'(w_acc_term); w_mul_b = (2*W)'(uy_q); end
            default: ;
        endcase
    end

    assign w_mul_w = W'((w_mul_a * w_mul_b) >>> FRAC);

    // ------------------------------------------------------------------
    // Shared signed divider for the unit-vector terms. The divisor is
    // only consumed in UX/UY where d > 0 is guaranteed; the zero guard
    // just keeps the idle divider well defined.
    // ------------------------------------------------------------------
    logic signed [W-1:0] w_div_num, w_div_den, w_quot;
    assign w_div_num = (state_q == UY) ? (dy_q <<< FRAC) : (dx_q <<< FRAC);
    assign w_div_den = (d_q == '0) ? C_ONE : d_q;
    assign w_quot    = w_div_num / w_div_den;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = INTEG;
                    k_d     = '0;
                end
            end
            INTEG: begin
                k_d     = '0;
                state_d = (PINNED != 0) ? CLAMP : DX2;
            end
            DX2:  state_d = DY2;
            DY2:  state_d = DIST;
            DIST: begin
                if (!w_skip) begin
                    state_d = UX;
                end else if (k_q == C_K_LAST) begin
                    state_d = CLAMP;
                end else begin
                    state_d = DX2;
                    k_d     = k_q + C_K_ONE;
                end
            end
            UX:   state_d = UY;
            UY:   state_d = DMX;
            DMX:  state_d = DMY;
            DMY:  state_d = ACCX;
            ACCX: state_d = ACCY;
            ACCY: begin
                if (k_q == C_K_LAST) begin
                    state_d = CLAMP;
                end else begin
                    state_d = DX2;
                    k_d     = k_q + C_K_ONE;
                end
            end
            CLAMP:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath next-state
    // ------------------------------------------------------------------
    always_comb begin
        px_d   = px_q;   pxo_d  = pxo_q;
        py_d   = py_q;   pyo_d  = pyo_q;
        vx_d   = vx_q;   vy_d   = vy_q;
        ax_d   = ax_q;   ay_d   = ay_q;
        fx_d   = fx_q;   fy_d   = fy_q;
        snx_d  = snx_q;  sny_d  = sny_q;
        snvx_d = snvx_q; snvy_d = snvy_q;
        dx_d   = dx_q;   dy_d   = dy_q;
        dx2_d  = dx2_q;  dy2_d  = dy2_q;
        d_d    = d_q;
        ux_d   = ux_q;   uy_d   = uy_q;
        dmx_d  = dmx_q;  dmy_d  = dmy_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    fx_d   = force_x;
                    fy_d   = force_y;
                    snx_d  = nbr_x;
                    sny_d  = nbr_y;
                    snvx_d = nbr_vx;
                    snvy_d = nbr_vy;
                end
            end
            INTEG: begin
                pxo_d = px_q;
                px_d  = w_pxn;
                vx_d  = w_vxn;
                ax_d  = '0;
                pyo_d = py_q;
                py_d  = w_pyn;
                vy_d  = w_vyn;
                ay_d  = '0;
            end
            DX2: begin
                dx_d  = w_dx;
                dx2_d = w_mul_w;
            end
            DY2: begin
                dy_d  = w_dy;
                dy2_d = w_mul_w;
            end
            DIST: d_d   = w_d_sum;
            UX:   ux_d  = w_quot;
            UY:   uy_d  = w_quot;
            DMX:  dmx_d = w_mul_w;
            DMY:  dmy_d = w_mul_w;
            ACCX: ax_d  = ax_q + w_mul_w;
            ACCY: ay_d  = ay_q + w_mul_w;
            CLAMP: begin
                // A wall hit reflects the velocity at half magnitude
                if (px_q[W-1]) begin
                    px_d = '0;
                    vx_d = -(vx_q >>> 1);
                end else if (px_q >= C_BOUND) begin
                    px_d = C_BOUND_M1;
                    vx_d = -(vx_q >>> 1);
                end
                if (py_q[W-1]) begin
                    py_d = '0;
                    vy_d = -(vy_q >>> 1);
                end else if (py_q >= C_BOUND) begin
                    py_d = C_BOUND_M1;
                    vy_d = -(vy_q >>> 1);
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            k_q     <= '0;
            px_q    <= C_INIT_X;
            pxo_q   <= C_INIT_X;
            py_q    <= C_INIT_Y;
            pyo_q   <= C_INIT_Y;
            vx_q    <= '0;
            vy_q    <= '0;
            ax_q    <= '0;
            ay_q    <= '0;
            fx_q    <= '0;
            fy_q    <= '0;
            snx_q   <= '0;
            sny_q   <= '0;
            snvx_q  <= '0;
            snvy_q  <= '0;
            dx_q    <= '0;
            dy_q    <= '0;
            dx2_q   <= '0;
            dy2_q   <= '0;
            d_q     <= '0;
            ux_q    <= '0;
            uy_q    <= '0;
            dmx_q   <= '0;
            dmy_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            px_q    <= px_d;
            pxo_q   <= pxo_d;
            py_q    <= py_d;
            pyo_q   <= pyo_d;
            vx_q    <= vx_d;
            vy_q    <= vy_d;
            ax_q    <= ax_d;
            ay_q    <= ay_d;
            fx_q    <= fx_d;
            fy_q    <= fy_d;
            snx_q   <= snx_d;
            sny_q   <= sny_d;
            snvx_q  <= snvx_d;
            snvy_q  <= snvy_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            dx2_q   <= dx2_d;
            dy2_q   <= dy2_d;
            d_q     <= d_d;
            ux_q    <= ux_d;
            uy_q    <= uy_d;
            dmx_q   <= dmx_d;
            dmy_q   <= dmy_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign busy  = (state_q != IDLE);
    assign done  = (state_q == DONE);
    assign x     = px_q;
    assign y     = py_q;
    assign vel_x = vx_q;
    assign vel_y = vy_q;

endmodule
`default_nettype wire

// File: tb/tb_spring_particle.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spring_particle
//  Description : Self-checking bench for spring_particle. Four instances with
//                different parameter sets share one clock and reset:
//                  0 default (3 neighbours), 1 pinned, 2 pinned near the wall,
//                  3 single neighbour with REST=32.
//                Expected step results are queued when a step is launched and
//                compared when the instance raises done.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spring_particle;

    localparam int NI = 4;

    logic clk = 1'b0;
    logic reset;

    logic               start_v [NI];
    logic signed [15:0] fx_v    [NI];
    logic signed [15:0] fy_v    [NI];
    logic               busy_v  [NI];
    logic               done_v  [NI];
    logic signed [15:0] x_v     [NI];
    logic signed [15:0] y_v     [NI];
    logic signed [15:0] vx_v    [NI];
    logic signed [15:0] vy_v    [NI];

    logic [47:0] nb3_pos;
    logic [47:0] nb3_zero;
    logic [15:0] nb1_x, nb1_y, nb1_v;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic signed [31:0] x;
        logic signed [31:0] y;
        logic signed [31:0] vx;
        logic signed [31:0] vy;
        int                 lat;
    } exp_t;

    exp_t sb [$];

    always #5 clk = ~clk;

    spring_particle #(.W(16), .FRAC(4)) u_def (
        .clk(clk), .reset(reset), .start(start_v[0]),
        .force_x(fx_v[0]), .force_y(fy_v[0]),
        .nbr_x(nb3_pos), .nbr_y(nb3_pos), .nbr_vx(nb3_zero), .nbr_vy(nb3_zero),
        .busy(busy_v[0]), .done(done_v[0]),
        .x(x_v[0]), .y(y_v[0]), .vel_x(vx_v[0]), .vel_y(vy_v[0])
    );

    spring_particle #(.W(16), .FRAC(4), .PINNED(1), .FORCE_SHIFT(4)) u_pin (
        .clk(clk), .reset(reset), .start(start_v[1]),
        .force_x(fx_v[1]), .force_y(fy_v[1]),
        .nbr_x(nb3_zero), .nbr_y(nb3_zero), .nbr_vx(nb3_zero), .nbr_vy(nb3_zero),
        .busy(busy_v[1]), .done(done_v[1]),
        .x(x_v[1]), .y(y_v[1]), .vel_x(vx_v[1]), .vel_y(vy_v[1])
    );

    spring_particle #(.W(16), .FRAC(4), .PINNED(1), .INIT_X(250), .FORCE_SHIFT(4)) u_clp (
        .clk(clk), .reset(reset), .start(start_v[2]),
        .force_x(fx_v[2]), .force_y(fy_v[2]),
        .nbr_x(nb3_zero), .nbr_y(nb3_zero), .nbr_vx(nb3_zero), .nbr_vy(nb3_zero),
        .busy(busy_v[2]), .done(done_v[2]),
        .x(x_v[2]), .y(y_v[2]), .vel_x(vx_v[2]), .vel_y(vy_v[2])
    );

    spring_particle #(.N_NEIGH(1), .W(16), .FRAC(4), .REST(32)) u_one (
        .clk(clk), .reset(reset), .start(start_v[3]),
        .force_x(fx_v[3]), .force_y(fy_v[3]),
        .nbr_x(nb1_x), .nbr_y(nb1_y), .nbr_vx(nb1_v), .nbr_vy(nb1_v),
        .busy(busy_v[3]), .done(done_v[3]),
        .x(x_v[3]), .y(y_v[3]), .vel_x(vx_v[3]), .vel_y(vy_v[3])
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Launch one step on instance id. The accepting edge counts as cycle 1;
    // done must be seen at cycle elat. start stays high for 'hold' cycles.
    task automatic run_step(input string tag, input int id,
                            input int ex, input int ey, input int evx, input int evy,
                            input int elat, input int hold);
        exp_t e;
        int   cnt;
        bit   busy_ok;
        e.x = ex; e.y = ey; e.vx = evx; e.vy = evy; e.lat = elat;
        sb.push_back(e);
        start_v[id] = 1'b1;
        tick();
        cnt     = 1;
        busy_ok = 1'b1;
        while (done_v[id] !== 1'b1 && cnt < 400) begin
            if (busy_v[id] !== 1'b1) busy_ok = 1'b0;
            if (cnt > hold) start_v[id] = 1'b0;
            tick();
            cnt++;
        end
        if (cnt > hold) start_v[id] = 1'b0;
        e = sb.pop_front();
        check({tag, ".lat"},  cnt,        e.lat);
        check({tag, ".busy"}, busy_ok,    1);
        check({tag, ".x"},    x_v[id],    e.x);
        check({tag, ".y"},    y_v[id],    e.y);
        check({tag, ".vx"},   vx_v[id],   e.vx);
        check({tag, ".vy"},   vy_v[id],   e.vy);
    endtask

    // Step out of DONE and confirm the instance is idle again
    task automatic finish_idle(input string tag, input int id);
        start_v[id] = 1'b0;
        tick();
        check({tag, ".idle_busy"}, busy_v[id], 0);
        check({tag, ".idle_done"}, done_v[id], 0);
    endtask

    initial begin
        reset = 1'b1;
        for (int i = 0; i < NI; i++) begin
            start_v[i] = 1'b0;
            fx_v[i]    = '0;
            fy_v[i]    = '0;
        end
        nb3_pos  = {3{16'd128}};
        nb3_zero = '0;
        nb1_x    = 16'd160;
        nb1_y    = 16'd128;
        nb1_v    = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Reset values
        check("rst.x",    x_v[0],    128);
        check("rst.y",    y_v[0],    128);
        check("rst.vx",   vx_v[0],   0);
        check("rst.vy",   vy_v[0],   0);
        check("rst.busy", busy_v[0], 0);
        check("rst.done", done_v[0], 0);
        check("rst.clpx", x_v[2],    250);
        check("rst.onex", x_v[3],    128);

        // Pinned: external force only
        fx_v[1] = 16'sd256;
        run_step("pin1", 1, 144, 128, 8, 0, 3, 0);
        finish_idle("pin1", 1);
        fy_v[1] = 16'sd64;
        run_step("pin2", 1, 176, 124, 16, -2, 3, 0);
        finish_idle("pin2", 1);

        // All neighbours coincident: every one skipped
        run_step("skip", 0, 128, 128, 0, 0, 12, 0);
        finish_idle("skip", 0);

        // Wall clamps, upper then lower
        fx_v[2] = 16'sd256;
        run_step("clp_hi", 2, 255, 128, -4, 0, 3, 0);
        finish_idle("clp_hi", 2);
        fx_v[2] = -16'sd8192;
        run_step("clp_lo", 2, 0, 128, 127, 0, 3, 0);
        finish_idle("clp_lo", 2);

        // Single spring neighbour over three steps
        run_step("one1", 3, 128, 128, 0, 0, 12, 0);
        finish_idle("one1", 3);
        run_step("one2", 3, 120, 128, -4, 0, 12, 0);
        finish_idle("one2", 3);
        run_step("one3", 3, 99, 128, -11, 0, 12, 0);
        finish_idle("one3", 3);

        // start kept high while busy is ignored
        run_step("ign", 0, 128, 128, 0, 0, 12, 5);
        finish_idle("ign", 0);

        // start held through DONE: one idle cycle, then the next step
        run_step("b2b1", 0, 128, 128, 0, 0, 12, 100);
        tick();
        check("b2b.gap_busy", busy_v[0], 0);
        run_step("b2b2", 0, 128, 128, 0, 0, 12, 0);
        finish_idle("b2b2", 0);

        // Reset in the middle of a step
        fx_v[0]    = 16'sd2560;
        start_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0;
        tick();
        tick();
        tick();
        check("mid.x_pre",    x_v[0],    138);
        check("mid.busy_pre", busy_v[0], 1);
        reset = 1'b1;
        tick();
        check("mid.busy", busy_v[0], 0);
        check("mid.done", done_v[0], 0);
        check("mid.x",    x_v[0],    128);
        check("mid.clpx", x_v[2],    250);
        check("mid.pinx", x_v[1],    128);
        check("mid.onevx", vx_v[3],  0);
        reset = 1'b0;
        tick();
        check("mid.after_busy", busy_v[0], 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
